// File: rtl/alu_ctrl_pkg.sv
// Shared ALU op encoding and the multiply sequencer FSM state encoding.
package alu_ctrl_pkg;

    // 4-bit ALU op codes shared by the decoder, the ALU and the sequencer
    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_LW   = 4'd2;
    localparam logic [3:0] ALU_SW   = 4'd3;
    localparam logic [3:0] ALU_ADDU = 4'd4;
    localparam logic [3:0] ALU_SUBU = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_BLEZ = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SRAV = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;
    localparam logic [3:0] ALU_SLTU = 4'd11;
    localparam logic [3:0] ALU_SLL  = 4'd12;
    localparam logic [3:0] ALU_SMUL = 4'd13;
    localparam logic [3:0] ALU_BGTZ = 4'd14;

    // Multiply sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Bundle of the CPU-side, multiply-handshake and ALU-side signals around the
// shared-ALU multiply sequencer.
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 32
);
    // CPU ALU request path
    logic [3:0]       cpu_ctrl_i;
    logic [WIDTH-1:0] cpu_src1_i;
    logic [WIDTH-1:0] cpu_src2_i;
    logic [WIDTH-1:0] cpu_result_o;
    logic             cpu_stall_o;

    // Multiply request handshake
    logic             mul_valid_i;
    logic             mul_ready_o;
    logic             mul_done_o;
    logic [WIDTH-1:0] mul_result_o;

    // Shared ALU connection
    logic [3:0]       alu_ctrl_o;
    logic [WIDTH-1:0] alu_src1_o;
    logic [WIDTH-1:0] alu_src2_o;
    logic [WIDTH-1:0] alu_result_i;

    // Requester side (CPU / decoder)
    modport master (
        output cpu_ctrl_i, cpu_src1_i, cpu_src2_i, mul_valid_i,
        input  cpu_result_o, cpu_stall_o, mul_ready_o, mul_done_o, mul_result_o
    );

    // Sequencer side
    modport slave (
        input  cpu_ctrl_i, cpu_src1_i, cpu_src2_i, mul_valid_i, alu_result_i,
        output cpu_result_o, cpu_stall_o, mul_ready_o, mul_done_o, mul_result_o,
        output alu_ctrl_o, alu_src1_o, alu_src2_o
    );

    // The shared ALU itself
    modport alu (
        input  alu_ctrl_o, alu_src1_o, alu_src2_o,
        output alu_result_i
    );

endinterface

// File: rtl/mul_seq_datapath.sv
// Shift-add multiply registers: partial product P, shifted multiplicand M,
// remaining multiplier Q and iteration counter, plus the loop exit test.
// The addition itself is done by the external ALU (P + M on the ADDU path).
module mul_seq_datapath #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_src1,
    input  logic [WIDTH-1:0] i_src2,
    input  logic [WIDTH-1:0] i_alu_result,
    output logic [WIDTH-1:0] o_p,
    output logic [WIDTH-1:0] o_m,
    output logic [WIDTH-1:0] o_p_next,
    output logic             o_last
);

    localparam int              CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_q_shift;
    logic             w_q_empty;
    logic             w_cnt_last;

    assign w_q_shift  = r_q >> 1;
    assign w_q_empty  = (w_q_shift == '0);
    assign w_cnt_last = (r_cnt == LAST_CNT);

    // Stop after the last real iteration, or once no multiplier bits remain
    assign o_last   = w_cnt_last || (EARLY_EXIT && w_q_empty);
    // Partial product after this iteration; the ALU supplies P + M
    assign o_p_next = r_q[0] ? i_alu_result : r_p;

    assign o_p = r_p;
    assign o_m = r_m;

    // Load operands on accept, then one shift-add iteration per RUN cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p   <= '0;
            r_m   <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_p   <= '0;
            r_m   <= i_src1;
            r_q   <= i_src2;
            r_cnt <= '0;
        end else if (i_step) begin
            r_p   <= o_p_next;
            r_m   <= r_m << 1;
            r_q   <= w_q_shift;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Owner of the shared ALU: passes single-cycle CPU ops straight through and,
// on a multiply request, borrows the ALU's ADDU path for an iterative
// shift-add multiply while holding the CPU pipeline.
module alu_mul_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    alu_mul_sequencer_if.slave bus
);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_m;
    logic [WIDTH-1:0] w_p_next;
    logic [WIDTH-1:0] r_mul_result;

    // Ready is high exactly in IDLE, so valid alone qualifies the accept there
    assign w_accept = (r_state == ST_IDLE) && bus.mul_valid_i;
    assign w_step   = (r_state == ST_RUN);

    mul_seq_datapath #(
        .WIDTH      (WIDTH),
        .EARLY_EXIT (EARLY_EXIT)
    ) u_datapath (
        .i_clk        (clk_i),
        .i_rst        (rst_i),
        .i_load       (w_accept),
        .i_step       (w_step),
        .i_src1       (bus.cpu_src1_i),
        .i_src2       (bus.cpu_src2_i),
        .i_alu_result (bus.alu_result_i),
        .o_p          (w_p),
        .o_m          (w_m),
        .o_p_next     (w_p_next),
        .o_last       (w_last)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE on exit, DONE -> IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_RUN;
            ST_RUN:  if (w_last)   w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ALU input mux, stall and handshake outputs per state
    always_comb begin
        bus.alu_ctrl_o  = bus.cpu_ctrl_i;
        bus.alu_src1_o  = bus.cpu_src1_i;
        bus.alu_src2_o  = bus.cpu_src2_i;
        bus.cpu_stall_o = 1'b0;
        bus.mul_ready_o = 1'b0;
        bus.mul_done_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.mul_ready_o = 1'b1;
                bus.cpu_stall_o = bus.mul_valid_i;
            end
            ST_RUN: begin
                bus.alu_ctrl_o  = ALU_ADDU;
                bus.alu_src1_o  = w_p;
                bus.alu_src2_o  = w_m;
                bus.cpu_stall_o = 1'b1;
            end
            ST_DONE: begin
                bus.mul_done_o = 1'b1;
            end
            default: begin
                bus.mul_ready_o = 1'b1;
            end
        endcase
    end

    // Capture the final partial product on the last RUN edge so it is valid
    // alongside the done pulse and held until the next multiply completes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mul_result <= '0;
        end else if (w_step && w_last) begin
            r_mul_result <= w_p_next;
        end
    end

    assign bus.mul_result_o = r_mul_result;
    assign bus.cpu_result_o = bus.alu_result_i;

endmodule
